// File: rtl/eth_pkg.sv
// Shared definitions for the Ethernet TX/RX framing blocks.
// Holds the framer state encoding, line constants and the FCS byte selector.
package eth_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    SFD,
    DATA,
    PAD,
    FCS,
    IFG
  } tx_state_t;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam logic [31:0] CRC_INIT      = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_POLY_REFL = 32'hEDB8_8320;
  localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB_20E3;
  localparam int          PRE_LEN       = 7;
  localparam logic [10:0] BYTE_CNT_MAX  = 11'h7FF;

  // FCS goes out as the inverted CRC, least significant byte first.
  function automatic logic [7:0] fcs_byte(input logic [31:0] crc, input logic [1:0] idx);
    logic [31:0] fcs;
    fcs = ~crc;
    case (idx)
      2'd0:    return fcs[7:0];
      2'd1:    return fcs[15:8];
      2'd2:    return fcs[23:16];
      default: return fcs[31:24];
    endcase
  endfunction

endpackage

// File: rtl/eth_crc32_d8.sv
// One-byte update of the reflected CRC-32 (IEEE 802.3), purely combinational.
// Shared between the TX framer and the RX FCS checker.
module eth_crc32_d8
  import eth_pkg::*;
(
  input  logic [31:0] crc,
  input  logic [7:0]  data,
  output logic [31:0] crc_next
);

  logic [31:0] c;

  always_comb begin
    c = crc ^ {24'h0, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY_REFL) : (c >> 1);
    end
    crc_next = c;
  end

endmodule

// File: rtl/eth_tx_framer.sv
// GMII-style transmit framer: preamble/SFD insertion, min-length padding,
// FCS generation, underrun abort and inter-frame gap timing.
module eth_tx_framer
  import eth_pkg::*;
#(
  parameter int MIN_FRAME = 60,
  parameter int IFG_BYTES = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] i_data,
  input  logic       i_valid,
  input  logic       i_last,
  output logic       o_ready,
  output logic [7:0] o_tx_data,
  output logic       o_tx_en,
  output logic       o_busy,
  output logic       o_underrun
);

  localparam logic [10:0] MIN_LEN  = 11'(MIN_FRAME);
  localparam logic [2:0]  PRE_LAST = 3'(PRE_LEN - 1);
  // The IDLE cycle that samples i_valid supplies the last idle byte-time.
  localparam logic [7:0]  IFG_LAST = 8'(IFG_BYTES - 2);

  tx_state_t   state;
  logic [2:0]  pre_cnt;
  logic [10:0] byte_cnt;
  logic [10:0] cnt_inc;
  logic [1:0]  fcs_idx;
  logic [7:0]  ifg_cnt;
  logic [31:0] crc;
  logic [31:0] crc_upd;
  logic [7:0]  crc_in;

  assign crc_in  = (state == PAD) ? 8'h00 : i_data;
  assign cnt_inc = (byte_cnt == BYTE_CNT_MAX) ? byte_cnt : byte_cnt + 11'd1;
  assign o_ready = (state == DATA);

  eth_crc32_d8 u_crc (
    .crc      (crc),
    .data     (crc_in),
    .crc_next (crc_upd)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      pre_cnt    <= 3'd0;
      byte_cnt   <= 11'd0;
      fcs_idx    <= 2'd0;
      ifg_cnt    <= 8'd0;
      crc        <= CRC_INIT;
      o_tx_data  <= 8'h00;
      o_tx_en    <= 1'b0;
      o_busy     <= 1'b0;
      o_underrun <= 1'b0;
    end else begin
      o_underrun <= 1'b0;
      case (state)
        IDLE: begin
          o_tx_en   <= 1'b0;
          o_tx_data <= 8'h00;
          if (i_valid) begin
            state    <= PRE;
            o_busy   <= 1'b1;
            pre_cnt  <= 3'd0;
            byte_cnt <= 11'd0;
            crc      <= CRC_INIT;
          end
        end
        PRE: begin
          o_tx_en   <= 1'b1;
          o_tx_data <= PREAMBLE_BYTE;
          if (pre_cnt == PRE_LAST) begin
            state <= SFD;
          end else begin
            pre_cnt <= pre_cnt + 3'd1;
          end
        end
        SFD: begin
          o_tx_en   <= 1'b1;
          o_tx_data <= SFD_BYTE;
          state     <= DATA;
        end
        DATA: begin
          o_tx_en <= 1'b1;
          if (i_valid) begin
            o_tx_data <= i_data;
            crc       <= crc_upd;
            byte_cnt  <= cnt_inc;
            if (i_last) begin
              fcs_idx <= 2'd0;
              state   <= (cnt_inc < MIN_LEN) ? PAD : FCS;
            end
          end else begin
            // Starved mid-frame: first FCS byte goes out now, deliberately corrupted.
            o_tx_data  <= fcs_byte(crc, 2'd0) ^ 8'h01;
            fcs_idx    <= 2'd1;
            o_underrun <= 1'b1;
            state      <= FCS;
          end
        end
        PAD: begin
          o_tx_en   <= 1'b1;
          o_tx_data <= 8'h00;
          crc       <= crc_upd;
          byte_cnt  <= cnt_inc;
          if (cnt_inc >= MIN_LEN) begin
            fcs_idx <= 2'd0;
            state   <= FCS;
          end
        end
        FCS: begin
          o_tx_en   <= 1'b1;
          o_tx_data <= fcs_byte(crc, fcs_idx);
          fcs_idx   <= fcs_idx + 2'd1;
          if (fcs_idx == 2'd3) begin
            ifg_cnt <= 8'd0;
            state   <= IFG;
          end
        end
        IFG: begin
          o_tx_en   <= 1'b0;
          o_tx_data <= 8'h00;
          if (ifg_cnt == IFG_LAST) begin
            state  <= IDLE;
            o_busy <= 1'b0;
          end else begin
            ifg_cnt <= ifg_cnt + 8'd1;
          end
        end
        default: begin
          state     <= IDLE;
          o_tx_en   <= 1'b0;
          o_tx_data <= 8'h00;
          o_busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_eth_tx_framer.sv
// Directed bench for eth_tx_framer: table of frame lengths plus hand-written
// back-to-back, underrun and mid-frame reset sequences.
module tb_eth_tx_framer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] i_data = 8'h00;
  logic       i_valid = 1'b0;
  logic       i_last = 1'b0;
  logic       o_ready;
  logic [7:0] o_tx_data;
  logic       o_tx_en;
  logic       o_busy;
  logic       o_underrun;

  eth_tx_framer #(.MIN_FRAME(60), .IFG_BYTES(12)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_data     (i_data),
    .i_valid    (i_valid),
    .i_last     (i_last),
    .o_ready    (o_ready),
    .o_tx_data  (o_tx_data),
    .o_tx_en    (o_tx_en),
    .o_busy     (o_busy),
    .o_underrun (o_underrun)
  );

  always #4 clk = ~clk;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int len;
    int pat;
    int exp_cycles;
  } vec_t;
  vec_t vecs[6];

  logic [7:0] cap      [0:2047];
  logic [7:0] done_buf [0:2047];
  logic [7:0] exp_f    [0:2047];
  int cap_len = 0;
  int done_len = 0;
  int frame_done = 0;
  int low_run = 0;
  int last_gap = -1;
  int idle_bad = 0;
  int under_cnt = 0;
  int under_pos = -1;
  logic prev_en = 1'b0;

  always @(negedge clk) begin
    if (o_tx_en) begin
      if (!prev_en) begin
        last_gap = low_run;
        cap_len = 0;
      end
      if (cap_len < 2048) cap[cap_len] = o_tx_data;
      cap_len++;
      if (o_underrun) under_pos = cap_len - 1;
    end else begin
      if (o_tx_data !== 8'h00) idle_bad++;
      if (prev_en) begin
        for (int i = 0; i < cap_len && i < 2048; i++) done_buf[i] = cap[i];
        done_len = cap_len;
        frame_done++;
        low_run = 0;
      end
      low_run++;
    end
    if (o_underrun) under_cnt++;
    prev_en = o_tx_en;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  task automatic chk_ne(input string nm, input logic [31:0] act, input logic [31:0] bad);
    checks++;
    if (act === bad) begin
      failures++;
      $display("FAIL %s actual=%h required_not=%h", nm, act, bad);
    end
  endtask

  function automatic logic [7:0] pay_byte(input int pat, input int i);
    case (pat)
      0:       return 8'(i);
      1:       return 8'hAA;
      default: return 8'(i * 7 + 3);
    endcase
  endfunction

  // Bit-serial reference CRC, one message bit per step.
  function automatic logic [31:0] crc_bits(input logic [31:0] c_in, input logic [7:0] d);
    logic [31:0] c;
    logic fb;
    c = c_in;
    for (int b = 0; b < 8; b++) begin
      fb = c[0] ^ d[b];
      c = c >> 1;
      if (fb) c = c ^ 32'hEDB88320;
    end
    return c;
  endfunction

  task automatic sync_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input int len, input int pat, input int drop_at,
                            input bit hold, input int rst_at);
    int idx;
    int guard;
    bit acc;
    idx = 0;
    guard = 0;
    i_valid = 1'b1;
    i_data = pay_byte(pat, 0);
    i_last = (len == 1);
    while (idx < len && guard < len * 4 + 200) begin
      acc = i_valid && o_ready;
      @(posedge clk);
      #1;
      guard++;
      if (acc) begin
        idx++;
        if (rst_at >= 0 && idx == rst_at) begin
          rst = 1'b1;
          #1;
          chk("rst_mid_tx_en", 32'(o_tx_en), 32'd0);
          chk("rst_mid_tx_data", 32'(o_tx_data), 32'd0);
          chk("rst_mid_busy", 32'(o_busy), 32'd0);
          chk("rst_mid_ready", 32'(o_ready), 32'd0);
          i_valid = 1'b0;
          i_last = 1'b0;
          @(negedge clk);
          rst = 1'b0;
          return;
        end
        if (idx == drop_at) begin
          i_valid = 1'b0;
          i_last = 1'b0;
          return;
        end
        if (idx < len) begin
          i_data = pay_byte(pat, idx);
          i_last = (idx == len - 1);
        end
      end
    end
    if (idx < len) chk("send_timeout", 32'(idx), 32'(len));
    if (!hold) begin
      i_valid = 1'b0;
      i_last = 1'b0;
      i_data = 8'h00;
    end
  endtask

  task automatic wait_frame(input int fd);
    int g;
    g = 0;
    while (frame_done == fd && g < 3000) begin
      @(negedge clk);
      g++;
    end
    if (frame_done == fd) chk("frame_timeout", 32'(frame_done), 32'(fd + 1));
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    while (o_busy && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (o_busy) chk("idle_timeout", 32'(o_busy), 32'd0);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_frame(input string nm, input int len, input int pat, input int under_at);
    int n;
    int pl;
    int bad;
    int first_bad;
    logic [31:0] c;
    logic [31:0] fcs;
    logic [31:0] got_fcs;
    n = 0;
    for (int i = 0; i < 7; i++) begin exp_f[n] = 8'h55; n++; end
    exp_f[n] = 8'hD5; n++;
    pl = (under_at >= 0) ? under_at : len;
    for (int i = 0; i < pl; i++) begin exp_f[n] = pay_byte(pat, i); n++; end
    if (under_at < 0) begin
      while (n - 8 < 60) begin exp_f[n] = 8'h00; n++; end
    end
    c = 32'hFFFFFFFF;
    for (int i = 8; i < n; i++) c = crc_bits(c, exp_f[i]);
    fcs = ~c;
    if (under_at >= 0) fcs = fcs ^ 32'h1;
    for (int k = 0; k < 4; k++) begin exp_f[n] = fcs[k*8 +: 8]; n++; end

    chk($sformatf("%s_len", nm), 32'(done_len), 32'(n));
    bad = 0;
    first_bad = -1;
    for (int i = 0; i < n && i < done_len; i++) begin
      if (done_buf[i] !== exp_f[i]) begin
        if (first_bad < 0) first_bad = i;
        bad++;
      end
    end
    chk($sformatf("%s_bytes_bad_first_at_%0d", nm, first_bad), 32'(bad), 32'd0);
    if (done_len >= 12) begin
      got_fcs = {done_buf[done_len-1], done_buf[done_len-2], done_buf[done_len-3], done_buf[done_len-4]};
      chk($sformatf("%s_fcs", nm), got_fcs, fcs);
      c = 32'hFFFFFFFF;
      for (int i = 8; i < done_len; i++) c = crc_bits(c, done_buf[i]);
      if (under_at >= 0) chk_ne($sformatf("%s_residue", nm), c, 32'hDEBB20E3);
      else               chk($sformatf("%s_residue", nm), c, 32'hDEBB20E3);
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int fd;
    vecs[0] = '{60,   0, 72};
    vecs[1] = '{1,    1, 72};
    vecs[2] = '{1514, 2, 1526};
    vecs[3] = '{59,   2, 72};
    vecs[4] = '{61,   0, 73};
    vecs[5] = '{2,    2, 72};

    repeat (3) @(negedge clk);
    chk("reset_tx_en", 32'(o_tx_en), 32'd0);
    chk("reset_tx_data", 32'(o_tx_data), 32'd0);
    chk("reset_ready", 32'(o_ready), 32'd0);
    chk("reset_busy", 32'(o_busy), 32'd0);
    chk("reset_underrun", 32'(o_underrun), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int v = 0; v < 6; v++) begin
      sync_edge();
      fd = frame_done;
      send_frame(vecs[v].len, vecs[v].pat, -1, 1'b0, -1);
      wait_frame(fd);
      chk($sformatf("vec%0d_txen_cycles", v), 32'(done_len), 32'(vecs[v].exp_cycles));
      check_frame($sformatf("vec%0d", v), vecs[v].len, vecs[v].pat, -1);
      wait_idle();
    end

    // Back-to-back frames with i_valid never dropping.
    sync_edge();
    fd = frame_done;
    send_frame(60, 0, -1, 1'b1, -1);
    send_frame(60, 2, -1, 1'b0, -1);
    chk("b2b_first_done", 32'(frame_done), 32'(fd + 1));
    check_frame("b2b_a", 60, 0, -1);
    chk("b2b_gap", 32'(last_gap), 32'd12);
    fd = frame_done;
    wait_frame(fd);
    check_frame("b2b_b", 60, 2, -1);
    wait_idle();

    // Underrun after 20 payload bytes.
    sync_edge();
    under_cnt = 0;
    under_pos = -1;
    fd = frame_done;
    send_frame(40, 0, 20, 1'b0, -1);
    wait_frame(fd);
    check_frame("underrun", 40, 0, 20);
    chk("underrun_pulses", 32'(under_cnt), 32'd1);
    chk("underrun_pos", 32'(under_pos), 32'd28);
    chk("underrun_busy_in_ifg", 32'(o_busy), 32'd1);
    wait_idle();

    // Reset during payload byte 30, then a clean frame.
    sync_edge();
    send_frame(60, 0, -1, 1'b0, 30);
    repeat (3) @(negedge clk);
    sync_edge();
    fd = frame_done;
    send_frame(60, 2, -1, 1'b0, -1);
    wait_frame(fd);
    check_frame("after_rst", 60, 2, -1);
    wait_idle();

    chk("idle_data_zero", 32'(idle_bad), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
